// File: rtl/counter_ext.sv
// Bounded up/down counter with wrap or saturate behaviour, synchronous clear/load
// and an enable prescaler; wrap is a registered one-cycle pulse.
module counter_ext #(
   parameter int G_DATA_WIDTH = 8,
   parameter int G_COUNT_FROM = 0,
   parameter int G_COUNT_TO   = 128,
   parameter int G_STEP       = 1,
   parameter int G_SATURATE   = 0,
   parameter int G_PRESCALE   = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    load,
   input  logic [G_DATA_WIDTH-1:0] load_value,
   input  logic                    count_enable,
   input  logic                    count_down,
   output logic [G_DATA_WIDTH-1:0] count,
   output logic                    wrap,
   output logic                    at_min,
   output logic                    at_max
);

   localparam int PW = (G_PRESCALE > 1) ? $clog2(G_PRESCALE) : 1;
   localparam int XW = G_DATA_WIDTH + 1;

   // Bounds held one bit wider so count +/- step can never overflow silently.
   localparam logic [XW-1:0] C_FROM = XW'(G_COUNT_FROM);
   localparam logic [XW-1:0] C_TO   = XW'(G_COUNT_TO);
   localparam logic [XW-1:0] C_STEP = XW'(G_STEP);
   localparam logic [PW-1:0] C_PS_LAST = PW'(G_PRESCALE - 1);

   logic [G_DATA_WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]           presc_q, presc_d;
   logic                    wrap_q, wrap_d;

   logic [XW-1:0] cnt_x, lv_x, up_sum, dn_lim;
   logic          tick;

   assign cnt_x  = {1'b0, count_q};
   assign lv_x   = {1'b0, load_value};
   assign up_sum = cnt_x + C_STEP;
   assign dn_lim = C_FROM + C_STEP;
   assign tick   = count_enable && (presc_q == C_PS_LAST);

   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      wrap_d  = 1'b0;
      if (clear) begin
         count_d = C_FROM[G_DATA_WIDTH-1:0];
         presc_d = '0;
      end else if (load) begin
         if (lv_x < C_FROM)
            count_d = C_FROM[G_DATA_WIDTH-1:0];
         else if (lv_x > C_TO)
            count_d = C_TO[G_DATA_WIDTH-1:0];
         else
            count_d = load_value;
         presc_d = '0;
      end else if (count_enable) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (!count_down) begin
               if (up_sum <= C_TO) begin
                  count_d = up_sum[G_DATA_WIDTH-1:0];
               end else if (G_SATURATE != 0) begin
                  count_d = C_TO[G_DATA_WIDTH-1:0];
               end else begin
                  count_d = C_FROM[G_DATA_WIDTH-1:0];
                  wrap_d  = 1'b1;
               end
            end else begin
               if (cnt_x >= dn_lim) begin
                  count_d = count_q - C_STEP[G_DATA_WIDTH-1:0];
               end else if (G_SATURATE != 0) begin
                  count_d = C_FROM[G_DATA_WIDTH-1:0];
               end else begin
                  count_d = C_TO[G_DATA_WIDTH-1:0];
                  wrap_d  = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= C_FROM[G_DATA_WIDTH-1:0];
         presc_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count  = count_q;
   assign wrap   = wrap_q;
   assign at_min = (count_q == C_FROM[G_DATA_WIDTH-1:0]);
   assign at_max = (count_q == C_TO[G_DATA_WIDTH-1:0]);

endmodule

// File: tb/tb_counter_ext.sv
// Three counter_ext configurations share one stimulus stream; each is compared
// every cycle against an integer-arithmetic model of the counting rules.
module tb_counter_ext;

   logic       clock = 1'b0;
   logic       reset_n, clear, load, count_enable, count_down;
   logic [7:0] load_value;

   logic [7:0] cnt_a, cnt_b, cnt_c;
   logic       wr_a, wr_b, wr_c, mn_a, mn_b, mn_c, mx_a, mx_b, mx_c;

   int n_cmp = 0;
   int n_err = 0;

   // Per-instance configuration: defaults / step 3 wrap / step 3 saturate prescale 4
   int P_FROM [3] = '{0, 0, 2};
   int P_TO   [3] = '{128, 10, 10};
   int P_STEP [3] = '{1, 3, 3};
   int P_SAT  [3] = '{0, 0, 1};
   int P_PS   [3] = '{1, 1, 4};

   int m_cnt [3];
   int m_ps  [3];
   int m_wr  [3];

   always #5 clock = ~clock;

   counter_ext u_a (
      .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
      .load_value(load_value), .count_enable(count_enable), .count_down(count_down),
      .count(cnt_a), .wrap(wr_a), .at_min(mn_a), .at_max(mx_a));

   counter_ext #(.G_COUNT_TO(10), .G_STEP(3)) u_b (
      .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
      .load_value(load_value), .count_enable(count_enable), .count_down(count_down),
      .count(cnt_b), .wrap(wr_b), .at_min(mn_b), .at_max(mx_b));

   counter_ext #(.G_COUNT_FROM(2), .G_COUNT_TO(10), .G_STEP(3), .G_SATURATE(1),
                 .G_PRESCALE(4)) u_c (
      .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
      .load_value(load_value), .count_enable(count_enable), .count_down(count_down),
      .count(cnt_c), .wrap(wr_c), .at_min(mn_c), .at_max(mx_c));

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int obs_cnt(input int i);
      return (i == 0) ? int'(cnt_a) : (i == 1) ? int'(cnt_b) : int'(cnt_c);
   endfunction
   function automatic int obs_wr(input int i);
      return (i == 0) ? int'(wr_a) : (i == 1) ? int'(wr_b) : int'(wr_c);
   endfunction
   function automatic int obs_mn(input int i);
      return (i == 0) ? int'(mn_a) : (i == 1) ? int'(mn_b) : int'(mn_c);
   endfunction
   function automatic int obs_mx(input int i);
      return (i == 0) ? int'(mx_a) : (i == 1) ? int'(mx_b) : int'(mx_c);
   endfunction

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s.u%0d.count", tag, i), obs_cnt(i), m_cnt[i]);
         chk($sformatf("%s.u%0d.wrap", tag, i), obs_wr(i), m_wr[i]);
         chk($sformatf("%s.u%0d.at_min", tag, i), obs_mn(i), int'(m_cnt[i] == P_FROM[i]));
         chk($sformatf("%s.u%0d.at_max", tag, i), obs_mx(i), int'(m_cnt[i] == P_TO[i]));
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = P_FROM[i];
         m_ps[i]  = 0;
         m_wr[i]  = 0;
      end
   endfunction

   function automatic void model_edge(input bit cl, input bit ld, input int lv,
                                      input bit en, input bit dn);
      for (int i = 0; i < 3; i++) begin
         bit tk;
         m_wr[i] = 0;
         tk = 0;
         if (cl) begin
            m_cnt[i] = P_FROM[i];
            m_ps[i]  = 0;
         end else if (ld) begin
            m_cnt[i] = (lv < P_FROM[i]) ? P_FROM[i] : (lv > P_TO[i]) ? P_TO[i] : lv;
            m_ps[i]  = 0;
         end else if (en) begin
            m_ps[i]++;
            if (m_ps[i] == P_PS[i]) begin
               m_ps[i] = 0;
               tk = 1;
            end
         end
         if (tk && !dn) begin
            if (m_cnt[i] + P_STEP[i] <= P_TO[i]) m_cnt[i] += P_STEP[i];
            else if (P_SAT[i] != 0)              m_cnt[i] = P_TO[i];
            else begin m_cnt[i] = P_FROM[i]; m_wr[i] = 1; end
         end else if (tk && dn) begin
            if (m_cnt[i] - P_STEP[i] >= P_FROM[i]) m_cnt[i] -= P_STEP[i];
            else if (P_SAT[i] != 0)                m_cnt[i] = P_FROM[i];
            else begin m_cnt[i] = P_TO[i]; m_wr[i] = 1; end
         end
      end
   endfunction

   // Called just after a negedge: drive, clock once, advance the model, check.
   task automatic step(input string tag, input bit cl, input bit ld, input int lv,
                       input bit en, input bit dn);
      clear = cl; load = ld; load_value = 8'(lv); count_enable = en; count_down = dn;
      @(posedge clock);
      model_edge(cl, ld, lv, en, dn);
      @(negedge clock);
      check_all(tag);
   endtask

   initial begin
      bit dir;
      bit [3:0] en_pat [8];
      reset_n = 1'b0; clear = 0; load = 0; load_value = 0; count_enable = 0; count_down = 0;
      model_reset();
      repeat (2) @(negedge clock);
      check_all("reset");
      reset_n = 1'b1;

      // Enable held up: default instance runs 0..128 then wraps to 0
      for (int k = 0; k < 132; k++) step("up_run", 0, 0, 0, 1, 0);
      // Down from wherever each sits, crossing the lower bound
      for (int k = 0; k < 20; k++) step("down_run", 0, 0, 0, 1, 1);

      // Prescaler pattern with an enable-low hole
      step("clr", 1, 0, 0, 0, 0);
      en_pat = '{4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
      for (int k = 0; k < 8; k++) step("presc", 0, 0, 0, en_pat[k][0], 0);

      // Load clamping and priority
      step("load_hi", 0, 1, 200, 0, 0);
      step("load_50", 0, 1, 50, 0, 0);
      step("load_lo", 0, 1, 1, 0, 0);
      step("clr_ld", 1, 1, 99, 1, 0);
      step("load_max", 0, 1, 128, 0, 0);
      step("load_tick", 0, 1, 128, 1, 0);
      step("wrap_tick", 0, 0, 0, 1, 0);

      // Randomized traffic with occasional direction flips
      dir = 0;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 15) == 0) dir = ~dir;
         step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
              int'($urandom_range(0, 255)), ($urandom_range(0, 9) < 8), dir);
      end

      // Asynchronous reset mid-count, between clock edges
      step("load77", 0, 1, 77, 0, 0);
      step("run77", 0, 0, 0, 1, 0);
      step("run77", 0, 0, 0, 1, 0);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clock);
      check_all("rst_hold");
      reset_n = 1'b1;
      for (int k = 0; k < 10; k++) step("resume", 0, 0, 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
